// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - width limits, reset seed and primitive-polynomial tap table for lfsr_core
package lfsr_pkg;

   localparam int LFSR_MIN_W = 2;
   localparam int LFSR_MAX_W = 32;
   localparam logic [31:0] LFSR_SEED = 32'd1;

   function automatic logic [31:0] tap(input int t);
      return 32'd1 << (t - 1);
   endfunction

   // Tap t of the polynomial feeds back state bit t-1.
   function automatic logic [31:0] lfsr_taps(input int w);
      logic [31:0] m;
      m = '0;
      case (w)
         2:  m = tap(2)  | tap(1);
         3:  m = tap(3)  | tap(2);
         4:  m = tap(4)  | tap(3);
         5:  m = tap(5)  | tap(3);
         6:  m = tap(6)  | tap(5);
         7:  m = tap(7)  | tap(6);
         8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
         9:  m = tap(9)  | tap(5);
         10: m = tap(10) | tap(7);
         11: m = tap(11) | tap(9);
         12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
         13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
         14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
         15: m = tap(15) | tap(14);
         16: m = tap(16) | tap(15) | tap(13) | tap(4);
         17: m = tap(17) | tap(14);
         18: m = tap(18) | tap(11);
         19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
         20: m = tap(20) | tap(17);
         21: m = tap(21) | tap(19);
         22: m = tap(22) | tap(21);
         23: m = tap(23) | tap(18);
         24: m = tap(24) | tap(23) | tap(22) | tap(17);
         25: m = tap(25) | tap(22);
         26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
         27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
         28: m = tap(28) | tap(25);
         29: m = tap(29) | tap(27);
         30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
         31: m = tap(31) | tap(28);
         32: m = tap(32) | tap(22) | tap(2)  | tap(1);
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - free-running maximal-length Fibonacci LFSR, z[1] is MSB
// LFSR_LOAD_EN adds load/seed ports for synchronous seeding.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int n = 8
) (
   input  logic       clk,
   input  logic       rst,
`ifdef LFSR_LOAD_EN
   input  logic       load,
   input  logic [1:n] seed,
`endif
   output logic [1:n] z
);

   if (n < LFSR_MIN_W || n > LFSR_MAX_W) begin : g_bad_width
      $error("lfsr_core: parameter n must be within 2..32");
   end

   localparam logic [31:0]  TAP_ALL  = lfsr_taps(n);
   localparam logic [n-1:0] TAP_MASK = TAP_ALL[n-1:0];
   localparam logic [n-1:0] SEED     = LFSR_SEED[n-1:0];

   logic [n-1:0] r_state;
   logic         w_fb;
   logic [n-1:0] w_step;
   logic [n-1:0] w_next;

   assign w_fb   = ^(r_state & TAP_MASK);
   assign w_step = {r_state[n-2:0], w_fb};

`ifdef LFSR_LOAD_EN
   logic [n-1:0] w_seed;
   assign w_seed = seed;
   // An all-zero seed would lock the register up, so it loads the reset seed.
   assign w_next = !load ? w_step : ((w_seed == '0) ? SEED : w_seed);
`else
   assign w_next = w_step;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= SEED;
      else      r_state <= w_next;
   end

   assign z = r_state;

endmodule

// File: tb/tb_lfsr_core.sv
// tb/tb_lfsr_core.sv - self-checking bench for lfsr_core at widths 4, 8 and 16
module tb_lfsr_core;

   logic clk = 1'b0;
   logic rst8 = 1'b1, rst4 = 1'b1, rst16 = 1'b1;
   logic load8 = 1'b0;
   logic [1:8] seed8 = '0;
   logic [1:8] z8;
   logic [1:4] z4;
   logic [1:16] z16;

   int n_checks = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;
   longint m8 = 0, m4 = 0, m16 = 0;

   always #5 clk = ~clk;

   lfsr_core #(.n(8)) u_dut8 (
      .clk (clk),
      .rst (rst8),
`ifdef LFSR_LOAD_EN
      .load(load8),
      .seed(seed8),
`endif
      .z   (z8)
   );

   lfsr_core #(.n(4)) u_dut4 (
      .clk (clk),
      .rst (rst4),
`ifdef LFSR_LOAD_EN
      .load(1'b0),
      .seed(4'h0),
`endif
      .z   (z4)
   );

   lfsr_core #(.n(16)) u_dut16 (
      .clk (clk),
      .rst (rst16),
`ifdef LFSR_LOAD_EN
      .load(1'b0),
      .seed(16'h0),
`endif
      .z   (z16)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Next value from the polynomial taps: shift left, feed parity of tapped bits into bit 0.
   function automatic longint model_step(input longint z, input int w);
      int taps [4];
      longint fb;
      fb = 0;
      case (w)
         4:       taps = '{4, 3, 0, 0};
         8:       taps = '{8, 6, 5, 4};
         16:      taps = '{16, 15, 13, 4};
         default: taps = '{0, 0, 0, 0};
      endcase
      foreach (taps[i]) if (taps[i] > 0) fb = fb ^ ((z >> (taps[i] - 1)) & 1);
      return ((z << 1) | fb) & ((longint'(1) << w) - 1);
   endfunction

   always @(posedge clk or negedge rst8) begin
      if (!rst8)      m8 = 1;
`ifdef LFSR_LOAD_EN
      else if (load8) m8 = (seed8 == 0) ? 1 : longint'(seed8);
`endif
      else            m8 = model_step(m8, 8);
   end

   always @(posedge clk or negedge rst4) begin
      if (!rst4) m4 = 1;
      else       m4 = model_step(m4, 4);
   end

   always @(posedge clk or negedge rst16) begin
      if (!rst16) m16 = 1;
      else        m16 = model_step(m16, 16);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_z8", z8, m8);
         chk("model_z4", z4, m4);
         chk("model_z16", z16, m16);
      end
   end

   initial begin
      logic [7:0] exp_seq [8];
      bit seen8 [256];
      int steps;
      int repeats;
      int zeros;
      exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

      #2;
      rst8 = 1'b0; rst4 = 1'b0; rst16 = 1'b0;
      #1;
      chk("async_reset_no_clk_z8", z8, 8'h01);
      chk("async_reset_no_clk_z4", z4, 4'h1);
      chk("async_reset_no_clk_z16", z16, 16'h0001);
      chk_en = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("reset_hold_z8", z8, 8'h01);
      end
      rst8 = 1'b1; rst4 = 1'b1; rst16 = 1'b1;

      fork
         begin
            foreach (seen8[i]) seen8[i] = 1'b0;
            seen8[1] = 1'b1;
            steps = 0; repeats = 0; zeros = 0;
            for (int k = 1; k <= 300; k++) begin
               @(negedge clk);
               steps++;
               if (k <= 8) chk("seq_n8", z8, exp_seq[k-1]);
               if (z8 == 8'h01) break;
               if (z8 == 8'h00) zeros++;
               if (seen8[z8]) repeats++;
               seen8[z8] = 1'b1;
            end
            chk("period_n8", steps, 255);
            chk("no_repeat_n8", repeats, 0);
            chk("no_zero_n8", zeros, 0);

            repeat (5) @(negedge clk);
            chk("pre_async_z8", z8, 8'h23);
            @(posedge clk);
            #2 rst8 = 1'b0;
            #1 chk("async_mid_z8", z8, 8'h01);
            @(posedge clk);
            #1 chk("async_hold_edge_z8", z8, 8'h01);
            @(negedge clk);
            rst8 = 1'b1;
            @(negedge clk);
            chk("resume_1_z8", z8, 8'h02);
            @(negedge clk);
            chk("resume_2_z8", z8, 8'h04);

`ifdef LFSR_LOAD_EN
            load8 = 1'b1; seed8 = 8'hA5;
            @(negedge clk);
            chk("load_a5_z8", z8, 8'hA5);
            load8 = 1'b0;
            @(negedge clk);
            chk("load_succ_z8", z8, 8'h4A);
            load8 = 1'b1; seed8 = 8'h00;
            @(negedge clk);
            chk("load_zero_z8", z8, 8'h01);
            seed8 = 8'hA5;
            rst8 = 1'b0;
            @(posedge clk);
            #1 chk("rst_over_load_z8", z8, 8'h01);
            @(negedge clk);
            rst8 = 1'b1; load8 = 1'b0;
            @(negedge clk);
            chk("after_rst_load_z8", z8, 8'h02);
`endif
         end
         begin
            int c4;
            c4 = 0;
            do begin
               @(negedge clk);
               c4++;
            end while (z4 != 4'h1 && c4 < 100);
            chk("period_n4", c4, 15);
         end
         begin
            int c16;
            c16 = 0;
            do begin
               @(negedge clk);
               c16++;
            end while (z16 != 16'h0001 && c16 < 70000);
            chk("period_n16", c16, 65535);
         end
      join

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
